// File: rtl/ps2_direction_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: scan codes, direction encoding,
// FSM state types and the key-to-direction lookup.
package ps2_direction_decoder_pkg;

    localparam logic [7:0] ScExtend     = 8'hE0;
    localparam logic [7:0] ScBreak      = 8'hF0;
    localparam logic [7:0] ScArrowUp    = 8'h75;
    localparam logic [7:0] ScArrowDown  = 8'h72;
    localparam logic [7:0] ScArrowLeft  = 8'h6B;
    localparam logic [7:0] ScArrowRight = 8'h74;
    localparam logic [7:0] ScKeyW       = 8'h1D;
    localparam logic [7:0] ScKeyS       = 8'h1B;
    localparam logic [7:0] ScKeyA       = 8'h1C;
    localparam logic [7:0] ScKeyD       = 8'h23;

    typedef enum logic [1:0] {
        DirLeft  = 2'b00,
        DirRight = 2'b01,
        DirDown  = 2'b10,
        DirUp    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        FIdle,
        FData,
        FParity,
        FStop
    } frame_state_e;

    typedef enum logic [1:0] {
        DIdle,
        DExt,
        DBreak,
        DExtBreak
    } dec_state_e;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } key_map_t;

    // Arrow keys live in the extended set, WASD in the base set.
    function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = DirLeft;
        if (ext) begin
            case (code)
                ScArrowUp:    m.dir = DirUp;
                ScArrowDown:  m.dir = DirDown;
                ScArrowLeft:  m.dir = DirLeft;
                ScArrowRight: m.dir = DirRight;
                default:      m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                ScKeyW:  m.dir = DirUp;
                ScKeyS:  m.dir = DirDown;
                ScKeyA:  m.dir = DirLeft;
                ScKeyD:  m.dir = DirRight;
                default: m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// Keyboard-side and result signals of the PS/2 direction decoder.
interface ps2_direction_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       mv_left;
    logic       mv_right;
    logic       mv_down;
    logic       mv_up;
    logic       press_button;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  mv_left, mv_right, mv_down, mv_up, press_button, scan_code, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output mv_left, mv_right, mv_down, mv_up, press_button, scan_code, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, 11-bit frame FSM with odd parity check
// and an inactivity timeout that aborts partial frames.
module ps2_frame_rx
    import ps2_direction_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       frame_err_o
);

    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    logic [1:0]          clk_sync_q;
    logic [1:0]          dat_sync_q;
    logic                clk_prev_q;
    frame_state_e        state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                parity_ok_q, parity_ok_d;
    logic [TimeoutW-1:0] tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                fall;
    logic                bit_in;

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b00;
            dat_sync_q  <= 2'b00;
            clk_prev_q  <= 1'b0;
            state_q     <= FIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_ok_q <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        tmo_d       = '0;
        err_d       = 1'b0;
        done_o      = 1'b0;

        // Timeout only guards a frame in progress; an idle line may stay quiet forever.
        if (state_q != FIdle && !fall) begin
            if (tmo_q == TimeoutLast) begin
                err_d   = 1'b1;
                state_d = FIdle;
            end else begin
                tmo_d = tmo_q + TimeoutW'(1);
            end
        end

        if (fall) begin
            unique case (state_q)
                FIdle: begin
                    if (!bit_in) begin
                        state_d   = FData;
                        bit_cnt_d = 3'd0;
                    end
                end
                FData: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = FParity;
                    end
                end
                FParity: begin
                    parity_ok_d = ^{shift_q, bit_in};
                    state_d     = FStop;
                end
                FStop: begin
                    state_d = FIdle;
                    if (bit_in && parity_ok_q) begin
                        done_o = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_o      = shift_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to four direction flags: frame receiver plus make/break decoder
// for arrow keys (extended set) and WASD.
module ps2_direction_decoder
    import ps2_direction_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    ps2_direction_decoder_if.slave  bus
);

    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_err;

    dec_state_e dec_q, dec_d;
    logic [3:0] mv_q, mv_d;
    logic [7:0] scan_q, scan_d;
    logic       valid_q, valid_d;
    key_map_t   key;
    logic       is_ext;
    logic       is_break;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (bus.ps2_clk),
        .ps2_dat_i   (bus.ps2_dat),
        .data_o      (rx_data),
        .done_o      (rx_done),
        .frame_err_o (rx_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q   <= DIdle;
            mv_q    <= 4'b0000;
            scan_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            mv_q    <= mv_d;
            scan_q  <= scan_d;
            valid_q <= valid_d;
        end
    end

    assign is_ext   = (dec_q == DExt) || (dec_q == DExtBreak);
    assign is_break = (dec_q == DBreak) || (dec_q == DExtBreak);
    assign key      = map_code(rx_data, is_ext);

    // Flags are registered on the same edge as scan_code so they move with code_valid.
    always_comb begin
        dec_d   = dec_q;
        mv_d    = mv_q;
        scan_d  = scan_q;
        valid_d = 1'b0;

        if (rx_err) begin
            dec_d = DIdle;
        end

        if (rx_done) begin
            scan_d  = rx_data;
            valid_d = 1'b1;
            if (rx_data == ScExtend && dec_q == DIdle) begin
                dec_d = DExt;
            end else if (rx_data == ScBreak && dec_q == DIdle) begin
                dec_d = DBreak;
            end else if (rx_data == ScBreak && dec_q == DExt) begin
                dec_d = DExtBreak;
            end else begin
                if (key.hit) begin
                    mv_d[key.dir] = ~is_break;
                end
                dec_d = DIdle;
            end
        end
    end

    assign bus.mv_left      = mv_q[DirLeft];
    assign bus.mv_right     = mv_q[DirRight];
    assign bus.mv_down      = mv_q[DirDown];
    assign bus.mv_up        = mv_q[DirUp];
    assign bus.press_button = |mv_q;
    assign bus.scan_code    = scan_q;
    assign bus.code_valid   = valid_q;
    assign bus.frame_err    = rx_err;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench: 1 MHz system clock so a 12.5 kHz PS/2 bit is 80 cycles and a
// 1 ms timeout is 1000 cycles; received bytes are checked against a scoreboard.
`timescale 1ns/1ps
module tb_ps2_direction_decoder;

    localparam int unsigned Timeout = 1000;
    localparam int unsigned HalfBit = 40;

    logic clk = 1'b0;
    logic reset;

    always #500 clk = ~clk;

    ps2_direction_decoder_if bus ();

    ps2_direction_decoder #(
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors     = 0;
    int checks     = 0;
    int cv_count   = 0;
    int ferr_count = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mv_vec();
        return {bus.mv_up, bus.mv_down, bus.mv_right, bus.mv_left};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_dat = b;
        wait_clk(HalfBit / 2);
        bus.ps2_clk = 1'b0;
        wait_clk(HalfBit);
        bus.ps2_clk = 1'b1;
        wait_clk(HalfBit / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good_parity);
        if (good_parity) exp_q.push_back(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(good_parity ? ~^b : ^b);
        ps2_bit(1'b1);
        bus.ps2_dat = 1'b1;
        wait_clk(100);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_err) ferr_count++;
            if (bus.code_valid) begin
                cv_count++;
                check("scb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("scan_code", bus.scan_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        #(100_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        reset       = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        wait_clk(5);
        check("rst_mv", mv_vec(), 4'b0000);
        check("rst_press", bus.press_button, 0);
        check("rst_scan", bus.scan_code, 8'h00);
        check("rst_valid", bus.code_valid, 0);
        check("rst_err", bus.frame_err, 0);
        reset = 1'b0;
        wait_clk(10);

        // Extended up arrow make then break
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        check("ext_up_make", mv_vec(), 4'b1000);
        check("ext_up_press", bus.press_button, 1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        check("ext_up_break", mv_vec(), 4'b0000);
        check("ext_up_release", bus.press_button, 0);

        // WASD left make then break
        cv_count = 0;
        send_frame(8'h1C, 1'b1);
        check("a_make", mv_vec(), 4'b0001);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        check("a_break", mv_vec(), 4'b0000);
        check("a_cv_count", cv_count, 3);

        // Parity error
        ferr_count = 0;
        send_frame(8'h6B, 1'b0);
        check("par_err_count", ferr_count, 1);
        check("par_scan_kept", bus.scan_code, 8'h1C);
        check("par_mv", mv_vec(), 4'b0000);

        // Timeout on a frame halted after four data bits
        ferr_count = 0;
        b = 8'h5A;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        bus.ps2_dat = 1'b1;
        wait_clk(Timeout + 200);
        check("tmo_err_count", ferr_count, 1);
        send_frame(8'h23, 1'b1);
        check("tmo_recover_right", mv_vec(), 4'b0010);

        // Reset during bit 5 of E0
        b = 8'hE0;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        bus.ps2_dat = b[5];
        wait_clk(HalfBit / 2);
        bus.ps2_clk = 1'b0;
        wait_clk(HalfBit / 2);
        reset = 1'b1;
        wait_clk(3);
        check("midrst_mv", mv_vec(), 4'b0000);
        reset = 1'b0;
        wait_clk(HalfBit / 2);
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        wait_clk(100);
        check("midrst_mv_after", mv_vec(), 4'b0000);
        check("midrst_press", bus.press_button, 0);
        check("midrst_scan", bus.scan_code, 8'h00);
        check("midrst_err", bus.frame_err, 0);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h72, 1'b1);
        check("down_after_rst", mv_vec(), 4'b0100);

        // Arrow and WASD share the up bit; typematic W keeps it set
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        check("shared_up_arrow", mv_vec(), 4'b1100);
        send_frame(8'h1D, 1'b1);
        check("shared_up_w", mv_vec(), 4'b1100);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1D, 1'b1);
        check("shared_up_break", mv_vec(), 4'b0100);

        check("scb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
PS2_DIRECTION_DECODER -- requirements
Module: ps2_direction_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
REQ-002 Port clk, input, 1, is the system clock (CLOCK_50 at top level).
REQ-003 Port reset, input, 1, is the reset; one clock; reset is asynchronous and active-high.
REQ-004 Port ps2_clk, input, 1, is the raw keyboard clock and is asynchronous to clk.
REQ-005 Port ps2_dat, input, 1, is the raw keyboard data and is asynchronous to clk.
REQ-006 Ports mv_left, mv_right, mv_down, mv_up, output, 1 each, are held high while the mapped key is held down.
REQ-007 Port press_button, output, 1, is the OR of the four mv_* outputs.
REQ-008 Port scan_code, output, 8, holds the last correctly received byte.
REQ-009 Port code_valid, output, 1, is a one-cycle pulse when scan_code updates.
REQ-010 Port frame_err, output, 1, is a one-cycle pulse on a parity, stop or timeout error.

Function
REQ-011 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized ps2_clk going 1->0 between consecutive cycles.
REQ-012 The frame FSM SHALL be F_IDLE->F_DATA->F_PARITY->F_STOP, advancing only on falling edges; data is sampled at the falling edge.
REQ-013 In F_IDLE, a sampled 0 (start bit) SHALL enter F_DATA; a sampled 1 SHALL stay in F_IDLE with no error.
REQ-014 F_DATA SHALL shift 8 bits LSB first, using a 3-bit counter; after bit 7 it enters F_PARITY.
REQ-015 Parity SHALL be odd: the 8 data bits plus the parity bit must contain an odd number of ones.
REQ-016 In F_STOP, a sampled 1 with good parity SHALL load scan_code and pulse code_valid on the next clk edge.
REQ-017 A bad parity or a stop bit of 0 SHALL pulse frame_err, discard the byte, and return the decoder FSM to D_IDLE.
REQ-018 In any state other than F_IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL pulse frame_err and return to F_IDLE; the timeout counter clears on every falling edge.
REQ-019 The decoder FSM has states D_IDLE, D_EXT, D_BREAK and D_EXT_BREAK, and advances once per code_valid.
REQ-020 Decoder transitions SHALL be:
- byte 0xE0: D_IDLE->D_EXT.
- byte 0xF0: D_IDLE->D_BREAK and D_EXT->D_EXT_BREAK.
- any other byte: apply its action, then go to D_IDLE.
REQ-021 Extended make codes SHALL set: 0x75 up, 0x72 down, 0x6B left, 0x74 right. Extended break codes (same bytes after E0 F0) SHALL clear them.
REQ-022 Non-extended make codes SHALL set: 0x1D up (W), 0x1B down (S), 0x1C left (A), 0x23 right (D). Non-extended break codes (after F0) SHALL clear them.
REQ-023 Unmapped codes SHALL leave all mv_* unchanged but still return the decoder to D_IDLE.
REQ-024 mv_* SHALL update in the same clk cycle that code_valid is high, i.e. one cycle after the stop-bit falling edge is detected.
REQ-025 Arrow and WASD keys for the same direction SHALL share one bit; a break from either clears it.
REQ-026 Typematic repeat makes SHALL re-set an already-set bit with no glitch.
REQ-027 Opposing directions MAY be high together; the consumer arbitrates.

Reset
REQ-028 On reset, all outputs SHALL be 0, scan_code 0x00, both FSMs idle, and the counters and synchronizers cleared.
REQ-029 Reset mid-frame SHALL discard the partial byte; after release, decoding SHALL resume at the next start bit.

Structure
REQ-030 The scan-code constants (E0, F0, arrow codes, WASD codes) and the direction encoding LEFT=00, RIGHT=01, DOWN=10, UP=11 SHALL live in a shared package reused by control.
REQ-031 One sub-module, ps2_frame_rx (synchronizer, frame FSM and timeout), SHALL feed the byte decoder, which sits in the top module.

Verification
REQ-032 Bench SHALL cover these directed scenarios at a 12.5 kHz PS/2 clock:
- Frames E0, 75 -> mv_up=1 and press_button=1. Then E0, F0, 75 -> mv_up=0.
- Frame 1C -> mv_left=1. Then F0, 1C -> mv_left=0; code_valid pulses exactly 3 times in total.
- Byte 0x6B sent with even parity -> frame_err pulses once, scan_code is unchanged, mv_* stay 0.
- Frame halted after 4 data bits for 60000 cycles -> frame_err pulses, then a good frame 0x23 gives mv_right=1.
- Reset asserted during bit 5 of E0 -> all outputs 0; the next frames E0, 72 -> mv_down=1.
- Frames E0, 75 then 1D then F0, 1D -> mv_up=0 after the final break.
